// File: rtl/bool_tt_pkg.sv
// Shared encodings for the truth-table sweeper: function selects and FSM states.
package bool_tt_pkg;

  localparam logic [1:0] MODE_NANDN = 2'd0;  // (~&x[N-1:1]) & ~x[0]
  localparam logic [1:0] MODE_NOR   = 2'd1;  // NOR of all bits
  localparam logic [1:0] MODE_PAR   = 2'd2;  // XOR parity
  localparam logic [1:0] MODE_MAJ   = 2'd3;  // popcount > N/2

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bool_fn.sv
// Combinational evaluator for the selectable boolean function of an N_IN-bit vector.
module bool_fn
  import bool_tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] x,
  input  logic [1:0]      mode,
  output logic            f
);

  logic       hi_and;
  logic [3:0] pop;

  // AND of the upper bits and population count. With a single input the upper
  // AND is empty; seeding it with 0 makes mode 0 collapse to ~x[0].
  always_comb begin
    hi_and = (N_IN > 1);
    pop    = '0;
    for (int i = 0; i < N_IN; i++) begin
      pop = pop + {3'b000, x[i]};
      if (i > 0) hi_and = hi_and & x[i];
    end
  end

  // Function select.
  always_comb begin
    f = 1'b0;
    case (mode)
      MODE_NANDN: f = ~hi_and & ~x[0];
      MODE_NOR:   f = ~|x;
      MODE_PAR:   f = ^x;
      MODE_MAJ:   f = (pop > 4'(N_IN / 2));
      default:    f = 1'b0;
    endcase
  end

endmodule

// File: rtl/bool_tt_sweep.sv
// Sweeps every input combination through bool_fn, capturing the truth table
// and counting true minterms.
//
//   state   | meaning
//   S_IDLE  | waiting for start; tt/ones_cnt hold the last result
//   S_SWEEP | writing tt[idx] each cycle, idx 0..TT_W-1
//   S_DONE  | one-cycle completion pulse, then back to idle
module bool_tt_sweep
  import bool_tt_pkg::*;
#(
  parameter  int N_IN = 3,
  localparam int TT_W = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] x_out,
  output logic            f_out,
  output logic [TT_W-1:0] tt,
  output logic [N_IN:0]   ones_cnt
);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [1:0]      mode_q;
  logic            f_eval;

  bool_fn #(.N_IN(N_IN)) u_fn (
    .x    (idx),
    .mode (mode_q),
    .f    (f_eval)
  );

  assign x_out = idx;
  assign f_out = f_eval;

  // Sweep controller with registered Moore outputs busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      mode_q   <= MODE_NANDN;
      tt       <= '0;
      ones_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SWEEP;
            busy     <= 1'b1;
            idx      <= '0;
            tt       <= '0;
            ones_cnt <= '0;
            mode_q   <= mode;
          end
        end
        S_SWEEP: begin
          tt[idx]  <= f_eval;
          ones_cnt <= ones_cnt + {{N_IN{1'b0}}, f_eval};
          if (idx == '1) begin
            // idx stays at the last entry so it never wraps within a sweep
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bool_tt_sweep.sv
// Directed bench for bool_tt_sweep at N_IN = 3, 4 and 1.
module tb_bool_tt_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // N_IN = 3
  logic       rst3_n, start3, busy3, done3, f3;
  logic [1:0] mode3;
  logic [2:0] x3;
  logic [7:0] tt3;
  logic [3:0] cnt3;
  // N_IN = 4
  logic        rst4_n, start4, busy4, done4, f4;
  logic [1:0]  mode4;
  logic [3:0]  x4;
  logic [15:0] tt4;
  logic [4:0]  cnt4;
  // N_IN = 1
  logic       rst1_n, start1, busy1, done1, f1;
  logic [1:0] mode1;
  logic [0:0] x1;
  logic [1:0] tt1;
  logic [1:0] cnt1;

  bool_tt_sweep #(.N_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .start(start3), .mode(mode3), .busy(busy3),
    .done(done3), .x_out(x3), .f_out(f3), .tt(tt3), .ones_cnt(cnt3)
  );
  bool_tt_sweep #(.N_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .mode(mode4), .busy(busy4),
    .done(done4), .x_out(x4), .f_out(f4), .tt(tt4), .ones_cnt(cnt4)
  );
  bool_tt_sweep #(.N_IN(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .mode(mode1), .busy(busy1),
    .done(done1), .x_out(x1), .f_out(f1), .tt(tt1), .ones_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // done must never be high on two consecutive cycles
  logic done3_prev = 1'b0;
  always @(negedge clk) begin
    if (done3_prev) chk("done3_single", done3, 1'b0);
    done3_prev <= done3;
  end

  // Full sweep on the N_IN=3 instance; mode input is flipped after acceptance
  // to show it has no effect.
  task automatic sweep3(input logic [1:0] m, input logic [7:0] exp_tt, input logic [3:0] exp_cnt);
    start3 = 1'b1;
    mode3  = m;
    tick();
    start3 = 1'b0;
    mode3  = ~m;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("busy3[%0d]", i), busy3, 1'b1);
      chk($sformatf("x3[%0d]", i), x3, i);
      chk($sformatf("f3[%0d] m%0d", i, m), f3, exp_tt[i]);
      tick();
    end
    chk("done3", done3, 1'b1);
    chk("busy3_done", busy3, 1'b0);
    chk("x3_held", x3, 3'd7);
    chk($sformatf("tt3 m%0d", m), tt3, exp_tt);
    chk($sformatf("cnt3 m%0d", m), cnt3, exp_cnt);
    tick();
    chk("done3_drop", done3, 1'b0);
  endtask

  initial begin
    rst3_n = 1'b0; rst4_n = 1'b0; rst1_n = 1'b0;
    start3 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    mode3  = 2'd0; mode4  = 2'd0; mode1  = 2'd0;
    #12;
    chk("rst_busy3", busy3, 1'b0);
    chk("rst_done3", done3, 1'b0);
    chk("rst_tt3", tt3, 8'h00);
    chk("rst_cnt3", cnt3, 4'd0);
    chk("rst_x3", x3, 3'd0);
    chk("rst_f3", f3, 1'b1);
    chk("rst_f4", f4, 1'b1);
    chk("rst_f1", f1, 1'b1);
    tick();
    rst3_n = 1'b1; rst4_n = 1'b1; rst1_n = 1'b1;
    tick();

    sweep3(2'd0, 8'h15, 4'd3);
    sweep3(2'd1, 8'h01, 4'd1);
    sweep3(2'd2, 8'h96, 4'd4);
    sweep3(2'd3, 8'hE8, 4'd4);

    // Held start: only IDLE accepts; one idle cycle between done and busy.
    start3 = 1'b1;
    mode3  = 2'd1;
    tick();
    mode3 = 2'd3;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hold_busy[%0d]", i), busy3, 1'b1);
      tick();
    end
    chk("hold_done", done3, 1'b1);
    chk("hold_tt_a", tt3, 8'h01);
    chk("hold_cnt_a", cnt3, 4'd1);
    tick();
    chk("hold_idle_busy", busy3, 1'b0);
    chk("hold_idle_done", done3, 1'b0);
    tick();
    chk("hold_rebusy", busy3, 1'b1);
    chk("hold_tt_clr", tt3, 8'h00);
    mode3 = 2'd0;
    for (int i = 0; i < 8; i++) tick();
    chk("hold_tt_b", tt3, 8'hE8);
    chk("hold_cnt_b", cnt3, 4'd4);
    start3 = 1'b0;
    tick();
    tick();
    chk("hold_stop", busy3, 1'b0);

    // Reset mid-sweep at idx=4 during a parity sweep.
    start3 = 1'b1;
    mode3  = 2'd2;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_x3", x3, 3'd4);
    chk("pre_rst_tt3", tt3, 8'h06);
    rst3_n = 1'b0;
    #1;
    chk("arst_tt3", tt3, 8'h00);
    chk("arst_cnt3", cnt3, 4'd0);
    chk("arst_busy3", busy3, 1'b0);
    chk("arst_x3", x3, 3'd0);
    tick();
    rst3_n = 1'b1;
    tick();
    sweep3(2'd2, 8'h96, 4'd4);

    // Result persists while idle, regardless of mode input.
    for (int i = 0; i < 20; i++) begin
      mode3 = 2'(i);
      tick();
      chk($sformatf("persist_tt[%0d]", i), tt3, 8'h96);
    end
    chk("persist_cnt", cnt3, 4'd4);

    // N_IN = 4 parity.
    start4 = 1'b1;
    mode4  = 2'd2;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("busy4[%0d]", i), busy4, 1'b1);
      chk($sformatf("f4[%0d]", i), f4, 16'h6996 >> i & 1);
      tick();
    end
    chk("done4", done4, 1'b1);
    chk("tt4", tt4, 16'h6996);
    chk("cnt4", cnt4, 5'd8);
    tick();
    chk("done4_drop", done4, 1'b0);

    // N_IN = 1, mode 0 reduces to ~x[0].
    start1 = 1'b1;
    mode1  = 2'd0;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy1[%0d]", i), busy1, 1'b1);
      chk($sformatf("x1[%0d]", i), x1, i);
      tick();
    end
    chk("done1", done1, 1'b1);
    chk("tt1", tt1, 2'b01);
    chk("cnt1", cnt1, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
